// File: rtl/ddr2_bridge_pkg.sv
// Shared state codes and constants for the DDR2 port bridge.
package ddr2_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StWrIssue = 3'd1;
  localparam state_t StWrAck   = 3'd2;
  localparam state_t StRdIssue = 3'd3;
  localparam state_t StRdWait  = 3'd4;
  localparam state_t StRdAck   = 3'd5;

  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEADBEEF;
  localparam logic [2:0]  AVM_BURST       = 3'd1;

endpackage

// File: rtl/ddr2_bridge_arb.sv
// Two-way round-robin arbiter; bit 0 is the write channel, bit 1 the read channel.
module ddr2_bridge_arb (
  input  logic       ctrl_clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] grant_o
);

  logic last_rd_q, last_rd_d;

  always_comb begin
    grant_o = 2'b00;
    if (grant_en_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_rd_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    last_rd_d = last_rd_q;
    if (|grant_o) last_rd_d = grant_o[1];
  end

  // Reset to "read granted last" so the write channel wins the first tie.
  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) last_rd_q <= 1'b1;
    else          last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/ddr2_port_bridge.sv
// Held-request word port to single-beat Avalon-MM bridge for the DDR2 controller.
// Optional read timeout is built when DDR2_BRIDGE_TIMEOUT_EN is defined.
module ddr2_port_bridge
  import ddr2_bridge_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AVM_ADDR_W = 25,
  parameter int unsigned BASE_WORD  = 0,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                  ctrl_clk,
  input  logic                  reset_n,
  input  logic                  ddr_init_done,
  input  logic [31:0]           write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  write,
  output logic                  write_waitrequest,
  input  logic [31:0]           read_addr,
  input  logic                  read,
  output logic                  read_waitrequest,
  output logic [DATA_W-1:0]     read_data,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [2:0]            avm_burstcount,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic                  rd_err
);

  state_t                  state_q, state_d;
  logic                    avm_write_q, avm_write_d;
  logic                    avm_read_q, avm_read_d;
  logic [AVM_ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic [DATA_W-1:0]       avm_writedata_q, avm_writedata_d;
  logic [DATA_W-1:0]       read_data_q, read_data_d;
  logic                    write_waitrequest_q, write_waitrequest_d;
  logic                    read_waitrequest_q, read_waitrequest_d;
  logic [1:0]              grant;
  logic [AVM_ADDR_W-1:0]   wr_word, rd_word;
  logic                    rd_timeout;

  assign wr_word = write_addr[AVM_ADDR_W+1:2] + AVM_ADDR_W'(BASE_WORD);
  assign rd_word = read_addr[AVM_ADDR_W+1:2] + AVM_ADDR_W'(BASE_WORD);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{write_addr[31:AVM_ADDR_W+2], write_addr[1:0],
                              read_addr[31:AVM_ADDR_W+2], read_addr[1:0]};

  ddr2_bridge_arb u_arb (
    .ctrl_clk   (ctrl_clk),
    .reset_n    (reset_n),
    .req_i      ({read, write}),
    .grant_en_i ((state_q == StIdle) && ddr_init_done),
    .grant_o    (grant)
  );

`ifdef DDR2_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic            rd_err_q, rd_err_d;

  always_comb begin
    rd_cnt_d = (state_q == StRdWait) ? rd_cnt_q + 1'b1 : '0;
    rd_err_d = rd_err_q | (rd_timeout && !avm_readdatavalid);
  end

  // rd_cnt_q counts completed RD_WAIT cycles, so this fires on the RD_TIMEOUT-th one.
  assign rd_timeout = (state_q == StRdWait) && (rd_cnt_q == CntW'(RD_TIMEOUT - 1));
  assign rd_err     = rd_err_q;

  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      rd_err_q <= rd_err_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = RD_TIMEOUT[0];
  assign rd_timeout = 1'b0;
  assign rd_err     = 1'b0;
`endif

  always_comb begin
    state_d             = state_q;
    avm_write_d         = avm_write_q;
    avm_read_d          = avm_read_q;
    avm_address_d       = avm_address_q;
    avm_writedata_d     = avm_writedata_q;
    read_data_d         = read_data_q;
    write_waitrequest_d = 1'b1;
    read_waitrequest_d  = 1'b1;
    case (state_q)
      StIdle: begin
        if (grant[0]) begin
          avm_address_d   = wr_word;
          avm_writedata_d = write_data;
          avm_write_d     = 1'b1;
          state_d         = StWrIssue;
        end else if (grant[1]) begin
          avm_address_d = rd_word;
          avm_read_d    = 1'b1;
          state_d       = StRdIssue;
        end
      end
      StWrIssue: begin
        if (!avm_waitrequest) begin
          avm_write_d         = 1'b0;
          write_waitrequest_d = 1'b0;
          state_d             = StWrAck;
        end
      end
      StRdIssue: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          read_data_d        = avm_readdata;
          read_waitrequest_d = 1'b0;
          state_d            = StRdAck;
        end else if (rd_timeout) begin
          read_data_d        = DATA_W'(RD_TIMEOUT_DATA);
          read_waitrequest_d = 1'b0;
          state_d            = StRdAck;
        end
      end
      StWrAck, StRdAck: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge ctrl_clk) begin
    if (!reset_n) begin
      state_q             <= StIdle;
      avm_write_q         <= 1'b0;
      avm_read_q          <= 1'b0;
      avm_address_q       <= '0;
      avm_writedata_q     <= '0;
      read_data_q         <= '0;
      write_waitrequest_q <= 1'b1;
      read_waitrequest_q  <= 1'b1;
    end else begin
      state_q             <= state_d;
      avm_write_q         <= avm_write_d;
      avm_read_q          <= avm_read_d;
      avm_address_q       <= avm_address_d;
      avm_writedata_q     <= avm_writedata_d;
      read_data_q         <= read_data_d;
      write_waitrequest_q <= write_waitrequest_d;
      read_waitrequest_q  <= read_waitrequest_d;
    end
  end

  assign avm_write         = avm_write_q;
  assign avm_read          = avm_read_q;
  assign avm_address       = avm_address_q;
  assign avm_writedata     = avm_writedata_q;
  assign avm_burstcount    = AVM_BURST;
  assign read_data         = read_data_q;
  assign write_waitrequest = write_waitrequest_q;
  assign read_waitrequest  = read_waitrequest_q;

endmodule
